// File: rtl/dna_hash_pkg.sv
// Shared DNA base encoding: 2-bit base codes plus ASCII decode and complement helpers.
package dna_hash_pkg;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } base_t;

    function automatic base_t encode_base(input logic [7:0] ch);
        base_t b;
        b.valid = 1'b1;
        b.code  = BASE_A;
        case (ch)
            8'h41, 8'h61: b.code = BASE_A;  // A a
            8'h43, 8'h63: b.code = BASE_C;  // C c
            8'h47, 8'h67: b.code = BASE_G;  // G g
            8'h54, 8'h74: b.code = BASE_T;  // T t
            default:      b.valid = 1'b0;
        endcase
        return b;
    endfunction

    // With A=0 C=1 G=2 T=3 the Watson-Crick partner is simply 3-code.
    function automatic logic [1:0] complement_base(input logic [1:0] code);
        return 2'd3 - code;
    endfunction

endpackage

// File: rtl/dna_base_decoder.sv
// Combinational ASCII to {valid, 2-bit code} decoder, shared with downstream blocks.
module dna_base_decoder (
    input  logic [7:0] in_char,
    output logic       valid,
    output logic [1:0] code
);
    import dna_hash_pkg::*;

    base_t dec;

    assign dec   = encode_base(in_char);
    assign valid = dec.valid;
    assign code  = dec.code;

endmodule

// File: rtl/kmer_rolling_hash_stream.sv
// Streaming k-mer hasher: rolling forward/reverse-complement windows, one character per cycle,
// single registered output stage with valid/ready back-pressure.
module kmer_rolling_hash_stream #(
    parameter int K         = 4,
    parameter int HASH_W    = 32,
    parameter int POS_W     = 16,
    parameter bit CANONICAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HASH_W-1:0] out_hash,
    output logic [POS_W-1:0]  out_pos,
    output logic              out_last,
    output logic              bad_char
);
    import dna_hash_pkg::*;

    localparam int KW    = 2 * K;
    localparam int RUN_W = $clog2(K + 1);

    logic [KW-1:0]    fwd, rev;
    logic [RUN_W-1:0] run;
    logic [POS_W-1:0] idx;

    logic             base_valid;
    logic [1:0]       base_code;

    dna_base_decoder u_decoder (
        .in_char (in_char),
        .valid   (base_valid),
        .code    (base_code)
    );

    logic             accept;
    logic [KW+1:0]    fwd_ext, rev_ext;
    logic [KW-1:0]    fwd_new, rev_new, hash_sel;
    logic [RUN_W-1:0] run_new;
    logic             emit;

    assign in_ready = rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Shifting through a 2K+2-bit concatenation keeps the K=1 case free of negative slices.
    assign fwd_ext  = {fwd, base_code};
    assign fwd_new  = fwd_ext[KW-1:0];
    assign rev_ext  = {complement_base(base_code), rev};
    assign rev_new  = rev_ext[KW+1:2];
    assign run_new  = (run == RUN_W'(K)) ? RUN_W'(K) : run + RUN_W'(1);
    assign emit     = accept && base_valid && (run_new == RUN_W'(K));
    assign hash_sel = (CANONICAL && (rev_new < fwd_new)) ? rev_new : fwd_new;

    // NOTE: every register here is updated with <= so all state advances from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd <= '0;
            rev <= '0;
            run <= '0;
            idx <= '0;
        end else if (accept) begin
            if (in_last) begin
                fwd <= '0;
                rev <= '0;
                run <= '0;
                idx <= '0;
            end else begin
                fwd <= base_valid ? fwd_new : '0;
                rev <= base_valid ? rev_new : '0;
                run <= base_valid ? run_new : '0;
                idx <= idx + POS_W'(1);
            end
        end
    end

    // Output stage holds its payload while stalled; a handshake and a new emit may share an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_hash  <= '0;
            out_pos   <= '0;
            out_last  <= 1'b0;
            bad_char  <= 1'b0;
        end else begin
            bad_char <= accept && !base_valid;
            if (emit) begin
                out_valid <= 1'b1;
                out_hash  <= HASH_W'(hash_sel);
                out_pos   <= idx - POS_W'(K - 1);
                out_last  <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
